fan_power_ctrl: RTL and testbench

Top-level fan/battery controller for the fan board. It runs at the 100 Hz system tick and turns debounced button pulses into the fan speed state. It models the battery charge level: drain while the fan runs, charge while the charger is connected. It drives fan_state, battery_level and battery_empty, which the seven-segment display block consumes directly.

---
 rtl/fan_pkg.sv | 23 ++
 rtl/battery_gauge.sv | 65 ++++++
 rtl/fan_power_ctrl.sv | 84 ++++++++
 tb/tb_fan_power_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fan_pkg.sv
// fan_pkg: shared fan-state encodings, FSM states and display-facing defaults.
// Contents: FAN_OFF/FAN_LOW/FAN_HIGH encodings, state_e, TICK_HZ_DEF, BAT_MAX_DEF, fan_of().
package fan_pkg;

    localparam logic [1:0] FAN_OFF  = 2'd0;
    localparam logic [1:0] FAN_LOW  = 2'd1;
    localparam logic [1:0] FAN_HIGH = 2'd2;

    localparam int TICK_HZ_DEF = 100;
    localparam int BAT_MAX_DEF = 99;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_LOW,
        ST_HIGH,
        ST_EMPTY
    } state_e;

    function automatic logic [1:0] fan_of(state_e s);
        return s == ST_LOW ? FAN_LOW : s == ST_HIGH ? FAN_HIGH : FAN_OFF;
    endfunction

endpackage

// File: rtl/battery_gauge.sv
// battery_gauge: battery level register with drain/charge period counters.
// Ports: clk, rst_n; run_mode_i (current fan speed), mode_chg_i (fan speed changes this edge),
//        charger_i; level_o (registered level), level_next_o (level after this edge),
//        depleted_o (this edge drains the last unit).
module battery_gauge
    import fan_pkg::*;
#(
    parameter int TICK_HZ      = TICK_HZ_DEF,
    parameter int DRAIN_LOW_S  = 2,
    parameter int DRAIN_HIGH_S = 1,
    parameter int CHARGE_S     = 1,
    parameter int BAT_MAX      = BAT_MAX_DEF,
    parameter int INIT_LEVEL   = 99
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] run_mode_i,
    input  logic       mode_chg_i,
    input  logic       charger_i,
    output logic [7:0] level_o,
    output logic [7:0] level_next_o,
    output logic       depleted_o
);

    localparam int LOW_P  = DRAIN_LOW_S * TICK_HZ;
    localparam int HIGH_P = DRAIN_HIGH_S * TICK_HZ;
    localparam int CHG_P  = CHARGE_S * TICK_HZ;
    localparam int DMAX   = LOW_P > HIGH_P ? LOW_P : HIGH_P;
    localparam int DW     = DMAX > 1 ? $clog2(DMAX) : 1;
    localparam int CW     = CHG_P > 1 ? $clog2(CHG_P) : 1;

    logic [DW-1:0] dcnt_q, dcnt_d, dlast;
    logic [CW-1:0] ccnt_q, ccnt_d;
    logic [7:0]    level_q, level_d;
    logic          draining, drain_step, chg_en, chg_step;

    // A speed change restarts the drain period, so no step is taken on that edge.
    assign draining   = !charger_i && !mode_chg_i && (run_mode_i == FAN_LOW || run_mode_i == FAN_HIGH);
    assign dlast      = run_mode_i == FAN_HIGH ? DW'(HIGH_P - 1) : DW'(LOW_P - 1);
    assign drain_step = draining && dcnt_q == dlast;
    assign chg_en     = charger_i && level_q < 8'(BAT_MAX);
    assign chg_step   = chg_en && ccnt_q == CW'(CHG_P - 1);

    assign dcnt_d  = (!draining || drain_step) ? '0 : dcnt_q + 1'b1;
    assign ccnt_d  = (!chg_en || chg_step) ? '0 : ccnt_q + 1'b1;
    assign level_d = chg_step ? level_q + 8'd1
                   : (drain_step && level_q != 8'd0) ? level_q - 8'd1 : level_q;

    assign depleted_o   = drain_step && level_q == 8'd1;
    assign level_o      = level_q;
    assign level_next_o = level_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt_q  <= '0;
            ccnt_q  <= '0;
            level_q <= 8'(INIT_LEVEL);
        end else begin
            dcnt_q  <= dcnt_d;
            ccnt_q  <= ccnt_d;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/fan_power_ctrl.sv
// fan_power_ctrl: fan speed FSM driven by debounced buttons, with battery drain/charge gauge.
// Ports: clk, rst_n (async, active low); btn_power, btn_speed (1-cycle pulses); charger_in;
//        fan_state (0 off, 1 low, 2 high), battery_level, battery_empty, charging (all registered).
module fan_power_ctrl
    import fan_pkg::*;
#(
    parameter int TICK_HZ       = TICK_HZ_DEF,
    parameter int DRAIN_LOW_S   = 2,
    parameter int DRAIN_HIGH_S  = 1,
    parameter int CHARGE_S      = 1,
    parameter int BAT_MAX       = BAT_MAX_DEF,
    parameter int INIT_LEVEL    = 99,
    parameter int RESTART_LEVEL = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_power,
    input  logic       btn_speed,
    input  logic       charger_in,
    output logic [1:0] fan_state,
    output logic [7:0] battery_level,
    output logic       battery_empty,
    output logic       charging
);

    state_e     state_q, state_d, btn_state;
    logic [1:0] fan_state_q;
    logic [7:0] level, level_next;
    logic       empty_q, charging_q, mode_chg, depleted;

    battery_gauge #(
        .TICK_HZ     (TICK_HZ),
        .DRAIN_LOW_S (DRAIN_LOW_S),
        .DRAIN_HIGH_S(DRAIN_HIGH_S),
        .CHARGE_S    (CHARGE_S),
        .BAT_MAX     (BAT_MAX),
        .INIT_LEVEL  (INIT_LEVEL)
    ) u_gauge (
        .clk         (clk),
        .rst_n       (rst_n),
        .run_mode_i  (fan_state_q),
        .mode_chg_i  (mode_chg),
        .charger_i   (charger_in),
        .level_o     (level),
        .level_next_o(level_next),
        .depleted_o  (depleted)
    );

    // Button-driven transitions only; depletion overrides them below. Power beats speed.
    always_comb begin
        btn_state = state_q;
        case (state_q)
            ST_OFF:   btn_state = (btn_power && level != 8'd0) ? ST_LOW : ST_OFF;
            ST_LOW:   btn_state = btn_power ? ST_OFF : btn_speed ? ST_HIGH : ST_LOW;
            ST_HIGH:  btn_state = btn_power ? ST_OFF : btn_speed ? ST_LOW : ST_HIGH;
            ST_EMPTY: btn_state = level >= 8'(RESTART_LEVEL) ? ST_OFF : ST_EMPTY;
            default:  btn_state = ST_OFF;
        endcase
    end

    // Kept apart from btn_state so the gauge's depleted strobe never loops back into mode_chg.
    assign mode_chg = fan_of(btn_state) != fan_of(state_q);
    assign state_d  = depleted ? ST_EMPTY : btn_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_OFF;
            fan_state_q <= FAN_OFF;
            empty_q     <= 1'b0;
            charging_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            fan_state_q <= fan_of(state_d);
            empty_q     <= state_d == ST_EMPTY;
            charging_q  <= charger_in && level_next < 8'(BAT_MAX);
        end
    end

    assign fan_state     = fan_state_q;
    assign battery_level = level;
    assign battery_empty = empty_q;
    assign charging      = charging_q;

endmodule

// File: tb/tb_fan_power_ctrl.sv
// tb_fan_power_ctrl: scenario tasks plus random stimulus checked against a cycle-count reference model.
module tb_fan_power_ctrl;

    localparam int TICK    = 10;
    localparam int MAXL    = 99;
    localparam int INITL   = 99;
    localparam int RESTART = 5;
    localparam int LOW_P   = 2 * TICK;
    localparam int HIGH_P  = 1 * TICK;
    localparam int CHG_P   = 1 * TICK;
    localparam logic [11:0] RST_V = {2'd0, 8'd99, 1'b0, 1'b0};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_power = 1'b0;
    logic       btn_speed = 1'b0;
    logic       charger_in = 1'b0;
    logic [1:0] fan_state;
    logic [7:0] battery_level;
    logic       battery_empty;
    logic       charging;
    logic [11:0] dv;

    int errors = 0;
    int checks = 0;

    int m_fan, m_lvl, m_age_d, m_age_c;
    bit m_empty, m_chg;

    fan_power_ctrl #(.TICK_HZ(TICK), .INIT_LEVEL(INITL)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_power    (btn_power),
        .btn_speed    (btn_speed),
        .charger_in   (charger_in),
        .fan_state    (fan_state),
        .battery_level(battery_level),
        .battery_empty(battery_empty),
        .charging     (charging)
    );

    always #5 clk = ~clk;

    assign dv = {fan_state, battery_level, battery_empty, charging};

    function automatic logic [11:0] model_vec();
        return {2'(m_fan), 8'(m_lvl), m_empty, m_chg};
    endfunction

    task automatic model_reset();
        m_fan = 0; m_lvl = INITL; m_age_d = 0; m_age_c = 0; m_empty = 0; m_chg = 0;
    endtask

    // Ages count consecutive qualifying cycles; a level step happens when an age reaches its period.
    task automatic model_step(input bit p, input bit s, input bit c);
        int nf = m_fan;
        int nl = m_lvl;
        bit ne = m_empty;
        if (m_empty) begin
            if (m_lvl >= RESTART) ne = 0;
        end else if (p) nf = (m_fan == 0) ? (m_lvl > 0 ? 1 : 0) : 0;
        else if (s && m_fan != 0) nf = 3 - m_fan;
        if (c) begin
            m_age_d = 0;
            if (m_lvl >= MAXL) m_age_c = 0;
            else begin
                m_age_c++;
                if (m_age_c == CHG_P) begin nl++; m_age_c = 0; end
            end
        end else begin
            m_age_c = 0;
            if (nf != m_fan || m_fan == 0) m_age_d = 0;
            else begin
                m_age_d++;
                if (m_age_d == (m_fan == 2 ? HIGH_P : LOW_P)) begin
                    m_age_d = 0;
                    nl--;
                    if (nl == 0) begin ne = 1; nf = 0; end
                end
            end
        end
        m_fan = nf; m_lvl = nl; m_empty = ne; m_chg = c && nl < MAXL;
    endtask

    task automatic tick(input bit p, input bit s, input bit c);
        btn_power = p; btn_speed = s; charger_in = c;
        @(posedge clk);
        model_step(p, s, c);
        #1;
        btn_power = 1'b0; btn_speed = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dv !== RST_V) begin errors++; $display("FAIL reset: got %h want %h", dv, RST_V); end
        rst_n = 1'b1;
    endtask

    task automatic test_power_on();
        tick(1, 0, 0);
        checks++;
        if (fan_state !== 2'd1) begin errors++; $display("FAIL power_on: fan_state got %0d want 1", fan_state); end
        checks++;
        if (dv !== model_vec()) begin errors++; $display("FAIL power_on_model: got %h want %h", dv, model_vec()); end
    endtask

    task automatic test_drain_low();
        for (int i = 1; i < LOW_P; i++) begin
            tick(0, 0, 0);
            checks++;
            if (dv !== model_vec()) begin errors++; $display("FAIL drain_low cyc %0d: got %h want %h", i, dv, model_vec()); end
        end
        checks++;
        if (battery_level !== 8'd99) begin errors++; $display("FAIL drain_low_early: level got %0d want 99", battery_level); end
        tick(0, 0, 0);
        checks++;
        if (battery_level !== 8'd98) begin errors++; $display("FAIL drain_low_step: level got %0d want 98", battery_level); end
    endtask

    task automatic test_speed_switch();
        repeat (5) tick(0, 0, 0);
        tick(0, 1, 0);
        checks++;
        if (fan_state !== 2'd2) begin errors++; $display("FAIL speed_high: fan_state got %0d want 2", fan_state); end
        for (int i = 1; i < HIGH_P; i++) begin
            tick(0, 0, 0);
            checks++;
            if (dv !== model_vec()) begin errors++; $display("FAIL speed_switch cyc %0d: got %h want %h", i, dv, model_vec()); end
        end
        checks++;
        if (battery_level !== 8'd98) begin errors++; $display("FAIL speed_clear: level got %0d want 98", battery_level); end
        tick(0, 0, 0);
        checks++;
        if (battery_level !== 8'd97) begin errors++; $display("FAIL speed_step: level got %0d want 97", battery_level); end
    endtask

    task automatic test_same_cycle();
        tick(0, 1, 0);
        checks++;
        if (fan_state !== 2'd1) begin errors++; $display("FAIL back_to_low: fan_state got %0d want 1", fan_state); end
        tick(1, 1, 0);
        checks++;
        if (fan_state !== 2'd0) begin errors++; $display("FAIL same_cycle: fan_state got %0d want 0", fan_state); end
        checks++;
        if (dv !== model_vec()) begin errors++; $display("FAIL same_cycle_model: got %h want %h", dv, model_vec()); end
    endtask

    task automatic test_saturate();
        tick(1, 0, 0);
        tick(0, 1, 0);
        for (int i = 0; i < 500; i++) begin
            tick(0, 0, 1);
            checks++;
            if (dv !== model_vec()) begin errors++; $display("FAIL saturate cyc %0d: got %h want %h", i, dv, model_vec()); end
        end
        checks++;
        if (dv !== {2'd2, 8'd99, 1'b0, 1'b0}) begin errors++; $display("FAIL saturate_end: got %h want %h", dv, {2'd2, 8'd99, 1'b0, 1'b0}); end
        tick(1, 0, 0);
    endtask

    task automatic test_depletion();
        tick(1, 0, 0);
        tick(0, 1, 0);
        for (int i = 0; i < 1200 && !m_empty; i++) begin
            tick(0, 0, 0);
            checks++;
            if (dv !== model_vec()) begin errors++; $display("FAIL deplete cyc %0d: got %h want %h", i, dv, model_vec()); end
        end
        checks++;
        if (dv !== {2'd0, 8'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL deplete_end: got %h want %h", dv, {2'd0, 8'd0, 1'b1, 1'b0}); end
        tick(1, 0, 0);
        tick(0, 1, 0);
        tick(1, 1, 0);
        checks++;
        if (dv !== {2'd0, 8'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL empty_ignore: got %h want %h", dv, {2'd0, 8'd0, 1'b1, 1'b0}); end
    endtask

    task automatic test_charge_exit();
        for (int i = 0; i < 3 * CHG_P; i++) begin
            tick(0, 0, 1);
            checks++;
            if (dv !== model_vec()) begin errors++; $display("FAIL charge cyc %0d: got %h want %h", i, dv, model_vec()); end
        end
        repeat (15) tick(0, 0, 0);
        checks++;
        if (dv !== {2'd0, 8'd3, 1'b1, 1'b0}) begin errors++; $display("FAIL unplug_hold: got %h want %h", dv, {2'd0, 8'd3, 1'b1, 1'b0}); end
        for (int i = 0; i < 100 && m_empty; i++) begin
            tick(0, 0, 1);
            checks++;
            if (dv !== model_vec()) begin errors++; $display("FAIL recharge cyc %0d: got %h want %h", i, dv, model_vec()); end
        end
        checks++;
        if (dv !== {2'd0, 8'd5, 1'b0, 1'b1}) begin errors++; $display("FAIL empty_exit: got %h want %h", dv, {2'd0, 8'd5, 1'b0, 1'b1}); end
        tick(0, 0, 0);
    endtask

    task automatic test_random();
        bit c = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) c = !c;
            tick($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0, c);
            checks++;
            if (dv !== model_vec()) begin errors++; $display("FAIL random cyc %0d: got %h want %h", i, dv, model_vec()); end
        end
        tick(0, 0, 0);
    endtask

    task automatic test_async_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
        tick(1, 0, 0);
        tick(0, 1, 0);
        for (int i = 0; i < 600 && m_lvl != 50; i++) begin
            tick(0, 0, 0);
            checks++;
            if (dv !== model_vec()) begin errors++; $display("FAIL to_fifty cyc %0d: got %h want %h", i, dv, model_vec()); end
        end
        checks++;
        if (dv !== {2'd2, 8'd50, 1'b0, 1'b0}) begin errors++; $display("FAIL at_fifty: got %h want %h", dv, {2'd2, 8'd50, 1'b0, 1'b0}); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dv !== RST_V) begin errors++; $display("FAIL async_reset: got %h want %h", dv, RST_V); end
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(1, 0, 0);
        checks++;
        if (dv !== model_vec()) begin errors++; $display("FAIL post_reset: got %h want %h", dv, model_vec()); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_power_on();
        test_drain_low();
        test_speed_switch();
        test_same_cycle();
        test_saturate();
        test_depletion();
        test_charge_exit();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
